// File: rtl/mat_addr_seq_if.sv
// Bus bundle between the matrix-multiply controller and mat_addr_seq.
// Carries the abort line only when MAT_ADDR_SEQ_ABORT_EN is defined.
interface mat_addr_seq_if #(
    parameter int data_width = 16,
    parameter int dim_width  = 8
);
    logic                  start;
    logic [dim_width-1:0]  n;
    logic [data_width-1:0] base_a;
    logic [data_width-1:0] base_b;
    logic [data_width-1:0] base_c;
    logic                  stall;
`ifdef MAT_ADDR_SEQ_ABORT_EN
    logic                  abort;
`endif
    logic [data_width-1:0] addr_out;
    logic                  addr_we;
    logic                  addr_dm;
    logic [1:0]            addr_kind;
    logic                  busy;
    logic                  done;

`ifdef MAT_ADDR_SEQ_ABORT_EN
    modport master (
        output start, n, base_a, base_b, base_c, stall, abort,
        input  addr_out, addr_we, addr_dm, addr_kind, busy, done
    );
    modport slave (
        input  start, n, base_a, base_b, base_c, stall, abort,
        output addr_out, addr_we, addr_dm, addr_kind, busy, done
    );
`else
    modport master (
        output start, n, base_a, base_b, base_c, stall,
        input  addr_out, addr_we, addr_dm, addr_kind, busy, done
    );
    modport slave (
        input  start, n, base_a, base_b, base_c, stall,
        output addr_out, addr_we, addr_dm, addr_kind, busy, done
    );
`endif
endinterface

// File: rtl/mat_addr_seq.sv
// Row-major A/B/C address sequencer for an NxN matrix product, built on running pointers.
// Optional abort input enabled by defining MAT_ADDR_SEQ_ABORT_EN.
module mat_addr_seq #(
    parameter int data_width = 16,
    parameter int dim_width  = 8
) (
    input logic          clk,
    input logic          rst,
    mat_addr_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EMIT_A = 3'd1,
        EMIT_B = 3'd2,
        EMIT_C = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam logic [1:0] KIND_A    = 2'd0;
    localparam logic [1:0] KIND_B    = 2'd1;
    localparam logic [1:0] KIND_C    = 2'd2;
    localparam logic [1:0] KIND_NONE = 2'd3;

    localparam logic [dim_width-1:0]  ONE_D = dim_width'(1);
    localparam logic [data_width-1:0] ONE_A = data_width'(1);

    state_t                state_q, state_nx;
    logic [dim_width-1:0]  n_q, n_nx;
    logic [dim_width-1:0]  i_q, i_nx;
    logic [dim_width-1:0]  j_q, j_nx;
    logic [dim_width-1:0]  k_q, k_nx;
    logic [data_width-1:0] base_b_q, base_b_nx;
    logic [data_width-1:0] a_row_q, a_row_nx;
    logic [data_width-1:0] a_ptr_q, a_ptr_nx;
    logic [data_width-1:0] b_ptr_q, b_ptr_nx;
    logic [data_width-1:0] c_ptr_q, c_ptr_nx;
    logic [data_width-1:0] addr_q, addr_nx;
    logic [1:0]            kind_q, kind_nx;

    logic                  emit;
    logic                  i_last, j_last, k_last;
    logic [data_width-1:0] n_ext;
    logic [data_width-1:0] j_ext;
    logic [data_width-1:0] a_next_row;

    function automatic logic [data_width-1:0] widen(input logic [dim_width-1:0] v);
        return data_width'(v);
    endfunction

    assign emit       = (state_q == EMIT_A) || (state_q == EMIT_B) || (state_q == EMIT_C);
    assign n_ext      = widen(n_q);
    assign j_ext      = widen(j_q);
    assign i_last     = (i_q == n_q - ONE_D);
    assign j_last     = (j_q == n_q - ONE_D);
    assign k_last     = (k_q == n_q - ONE_D);
    assign a_next_row = a_row_q + n_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            base_b_q <= '0;
            a_row_q  <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            c_ptr_q  <= '0;
            addr_q   <= '0;
            kind_q   <= KIND_NONE;
        end else begin
            state_q  <= state_nx;
            n_q      <= n_nx;
            i_q      <= i_nx;
            j_q      <= j_nx;
            k_q      <= k_nx;
            base_b_q <= base_b_nx;
            a_row_q  <= a_row_nx;
            a_ptr_q  <= a_ptr_nx;
            b_ptr_q  <= b_ptr_nx;
            c_ptr_q  <= c_ptr_nx;
            addr_q   <= addr_nx;
            kind_q   <= kind_nx;
        end
    end

    // addr_nx/kind_nx always describe what the next state will present.
    always_comb begin
        state_nx  = state_q;
        n_nx      = n_q;
        i_nx      = i_q;
        j_nx      = j_q;
        k_nx      = k_q;
        base_b_nx = base_b_q;
        a_row_nx  = a_row_q;
        a_ptr_nx  = a_ptr_q;
        b_ptr_nx  = b_ptr_q;
        c_ptr_nx  = c_ptr_q;
        addr_nx   = addr_q;
        kind_nx   = kind_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_nx      = bus.n;
                    base_b_nx = bus.base_b;
                    i_nx      = '0;
                    j_nx      = '0;
                    k_nx      = '0;
                    a_row_nx  = bus.base_a;
                    a_ptr_nx  = bus.base_a;
                    b_ptr_nx  = bus.base_b;
                    c_ptr_nx  = bus.base_c;
                    if (bus.n == '0) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = EMIT_A;
                        addr_nx  = bus.base_a;
                        kind_nx  = KIND_A;
                    end
                end
            end
            EMIT_A: begin
                if (!bus.stall) begin
                    state_nx = EMIT_B;
                    addr_nx  = b_ptr_q;
                    kind_nx  = KIND_B;
                end
            end
            EMIT_B: begin
                if (!bus.stall) begin
                    if (!k_last) begin
                        k_nx     = k_q + ONE_D;
                        a_ptr_nx = a_ptr_q + ONE_A;
                        b_ptr_nx = b_ptr_q + n_ext;
                        state_nx = EMIT_A;
                        addr_nx  = a_ptr_q + ONE_A;
                        kind_nx  = KIND_A;
                    end else begin
                        state_nx = EMIT_C;
                        addr_nx  = c_ptr_q;
                        kind_nx  = KIND_C;
                    end
                end
            end
            EMIT_C: begin
                if (!bus.stall) begin
                    c_ptr_nx = c_ptr_q + ONE_A;
                    k_nx     = '0;
                    if (!j_last) begin
                        // next column of B restarts at row 0: base_b + (j+1)
                        j_nx     = j_q + ONE_D;
                        a_ptr_nx = a_row_q;
                        b_ptr_nx = base_b_q + j_ext + ONE_A;
                        state_nx = EMIT_A;
                        addr_nx  = a_row_q;
                        kind_nx  = KIND_A;
                    end else if (!i_last) begin
                        i_nx     = i_q + ONE_D;
                        j_nx     = '0;
                        a_row_nx = a_next_row;
                        a_ptr_nx = a_next_row;
                        b_ptr_nx = base_b_q;
                        state_nx = EMIT_A;
                        addr_nx  = a_next_row;
                        kind_nx  = KIND_A;
                    end else begin
                        state_nx = FIN;
                        kind_nx  = KIND_NONE;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
                kind_nx  = KIND_NONE;
            end
            default: begin
                state_nx = IDLE;
                kind_nx  = KIND_NONE;
            end
        endcase

`ifdef MAT_ADDR_SEQ_ABORT_EN
        // Abort overrides stall; a fresh start reloads every pointer.
        if (emit && bus.abort) begin
            state_nx = IDLE;
            kind_nx  = KIND_NONE;
        end
`endif
    end

    assign bus.addr_out  = addr_q;
    assign bus.addr_kind = kind_q;
    assign bus.addr_we   = emit & ~bus.stall;
    assign bus.addr_dm   = emit & ~bus.stall;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);

endmodule

// File: tb/tb_mat_addr_seq.sv
// Scoreboard bench for mat_addr_seq: a loop model pushes the expected A/B/C stream,
// and a negedge monitor pops and compares every emitted address.
module tb_mat_addr_seq;

    localparam int DW = 16;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mat_addr_seq_if #(.data_width(DW), .dim_width(NW)) bus ();

    mat_addr_seq #(.data_width(DW), .dim_width(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [1:0]    kind;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    // Reference order: for each (i,j), A[i][k] and B[k][j] interleaved over k, then C[i][j].
    task automatic push_run(input int nn, input logic [DW-1:0] ba, input logic [DW-1:0] bb,
                            input logic [DW-1:0] bc);
        exp_t x;
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
                for (int k = 0; k < nn; k++) begin
                    x.addr = DW'(int'(ba) + i * nn + k);
                    x.kind = 2'd0;
                    q.push_back(x);
                    x.addr = DW'(int'(bb) + k * nn + j);
                    x.kind = 2'd1;
                    q.push_back(x);
                end
                x.addr = DW'(int'(bc) + i * nn + j);
                x.kind = 2'd2;
                q.push_back(x);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && bus.addr_we) begin
            if (q.size() == 0) begin
                check("extra_emit", 32'd1, 32'd0);
            end else begin
                e_mon = q.pop_front();
                check("addr", bus.addr_out, e_mon.addr);
                check("kind", bus.addr_kind, e_mon.kind);
                check("addr_dm", bus.addr_dm, 1);
            end
        end
    end

    task automatic run(input int nn, input logic [DW-1:0] ba, input logic [DW-1:0] bb,
                       input logic [DW-1:0] bc, input int st_at, input int st_len,
                       input logic [DW-1:0] hold, input int pulse_at);
        int exp_cyc;
        int cyc;
        bit seen;
        exp_cyc = nn * nn * (2 * nn + 1) + 1 + st_len;
        seen    = 1'b0;
        push_run(nn, ba, bb, bc);
        mon_en  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.n      = NW'(nn);
        bus.base_a = ba;
        bus.base_b = bb;
        bus.base_c = bc;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        for (cyc = 1; cyc <= exp_cyc + 20; cyc++) begin
            bus.stall = (cyc >= st_at) && (cyc < st_at + st_len);
            bus.start = (cyc == pulse_at);
            @(negedge clk);
            if (bus.stall) begin
                check("stall_we", bus.addr_we, 0);
                check("stall_hold", bus.addr_out, hold);
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_seen", seen, 1);
        check("done_cycle", cyc, exp_cyc);
        check("busy_at_done", bus.busy, 1);
        check("queue_empty", q.size(), 0);
        @(posedge clk); #1;
        bus.stall = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("busy_idle", bus.busy, 0);
        check("kind_idle", bus.addr_kind, 3);
        mon_en = 1'b0;
        q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.n      = '0;
        bus.base_a = '0;
        bus.base_b = '0;
        bus.base_c = '0;
        bus.stall  = 1'b0;
`ifdef MAT_ADDR_SEQ_ABORT_EN
        bus.abort  = 1'b0;
`endif
        @(negedge clk);
        check("rst_addr", bus.addr_out, 0);
        check("rst_kind", bus.addr_kind, 3);
        check("rst_we", bus.addr_we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(1, 16'h0010, 16'h0020, 16'h0030, 0, 0, 16'h0, 0);
        run(2, 16'h0000, 16'h0100, 16'h0200, 0, 0, 16'h0, 0);
        run(2, 16'h0000, 16'h0100, 16'h0200, 4, 3, 16'h0102, 0);
        run(0, 16'h0040, 16'h0050, 16'h0060, 0, 0, 16'h0, 0);
        run(2, 16'h0000, 16'h0100, 16'h0200, 0, 0, 16'h0, 5);
        run(2, 16'hFFFF, 16'h0100, 16'h0200, 0, 0, 16'h0, 0);
        run(3, 16'h1000, 16'h2000, 16'h3000, 0, 0, 16'h0, 0);

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.n      = NW'(2);
        bus.base_a = 16'h0004;
        bus.base_b = 16'h0104;
        bus.base_c = 16'h0204;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_addr", bus.addr_out, 0);
        check("mid_rst_kind", bus.addr_kind, 3);
        check("mid_rst_we", bus.addr_we, 0);
        check("mid_rst_dm", bus.addr_dm, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_done_after_rst", bus.done, 0);
            check("idle_after_rst", bus.busy, 0);
        end

`ifdef MAT_ADDR_SEQ_ABORT_EN
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.n      = NW'(2);
        bus.base_a = 16'h0000;
        bus.base_b = 16'h0100;
        bus.base_c = 16'h0200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.stall = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_in_b", bus.addr_kind, 1);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        check("abort_we", bus.addr_we, 0);
        check("abort_kind", bus.addr_kind, 3);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        run(2, 16'h0000, 16'h0100, 16'h0200, 0, 0, 16'h0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
